cp0_intr_ctrl: RTL
==================

Name: cp0_intr_ctrl

Overview:
CPU-side responder for the external `interrupt` line driven by the bench.
It holds the coprocessor-0 registers SR, Cause, EPC and PRId, samples six hardware interrupt lines, and arbitrates interrupts against exceptions reported by the M stage.
It raises a single-cycle-decided `req` that redirects the pipeline to the handler, and supports `eret` return.
It sits beside the M stage of the pipelined MIPS core; `mtc0`/`mfc0` access it through a register-number port.

Parameters:
PRID_VAL, 32'h2021_0007, constant value returned for PRId (reg 15)
HANDLER_ADDR, 32'h0000_4180, exception/interrupt entry PC presented on handler_pc

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  reset, synchronous, active-high
hwint  in  6  external interrupt lines; bit 0 is the top-level `interrupt`
pc_m  in  32  PC of the instruction in M stage
bd_m  in  1  M-stage instruction is in a branch delay slot
exccode_m  in  5  exception code of the M-stage instruction; 0 = none
eret_m  in  1  M-stage instruction is eret
we  in  1  mtc0 write enable
cp0_addr  in  5  register number for mtc0/mfc0
wdata  in  32  mtc0 data
rdata  out  32  mfc0 data, combinational
req  out  1  take interrupt/exception now (flush and redirect), combinational
handler_pc  out  32  constant HANDLER_ADDR
epc_out  out  32  return target for eret, combinational with forwarding
exl  out  1  current SR.EXL

Behaviour:
- SR (reg 12) fields:
  - IM = [15:10], EXL = [1], IE = [0].
  - All other bits read 0 and ignore writes.
- Cause (reg 13) fields:
  - BD = [31], IP = [15:10], ExcCode = [6:2].
  - All other bits read 0.
  - Cause is not software-writable; mtc0 to Cause is dropped.
- EPC (reg 14) is 32 bits and fully writable.
- PRId (reg 15) always reads PRID_VAL.
- Any other cp0_addr reads 0; writes to it are ignored.
- Reset: SR=0, Cause=0, EPC=0.
  - While reset is high, req is forced to 0 and no register updates except clearing.
  - Reset mid-handler clears EXL.
- IP sampling: Cause.IP <= hwint every posedge (not reset), regardless of EXL/IE/IM.
- Request logic, combinational:
  - int_req = IE & ~EXL & |(hwint & IM), using live hwint, not sampled IP.
  - exc_req = ~EXL & (exccode_m != 0).
  - req = int_req | exc_req.
- On posedge with req=1:
  - EXL <= 1.
  - BD <= bd_m.
  - EPC <= bd_m ? pc_m - 4 : pc_m (32-bit wrap, no alignment change).
  - ExcCode <= int_req ? 0 : exccode_m. Interrupt has priority over a simultaneous exception.
- Priority on the same edge:
  - req beats we: the mtc0 write is discarded entirely, since that instruction is being flushed.
  - req beats eret_m: EXL remains 1 and EPC takes the new value.
- eret_m=1 with req=0: EXL <= 0 at the edge.
  - A still-asserted, enabled hwint makes req=1 on the following cycle.
- mtc0 (we=1, req=0) takes effect at the edge; rdata reflects it from the next cycle.
- epc_out:
  - Equals wdata when we=1 and cp0_addr=14 in the same cycle.
  - Otherwise equals the EPC register.
- mtc0 setting EXL=0 or IE=1 with a pending enabled hwint: req asserts the cycle after the write.
- While EXL=1, hwint pulses of any length produce no req but still appear in Cause.IP.
- Latency:
  - req is zero-cycle from hwint or exccode_m.
  - Register effects are visible one cycle later.

Test Plan:
1. Reset -> rdata for regs 12/13/14 = 0, reg 15 = PRID_VAL, req=0, exl=0; reset asserted while EXL=1 -> exl=0 next cycle.
2. mtc0 SR=0x0000_0401, then hwint=6'b000001 for 6 cycles with pc_m=0x3010, bd_m=0:
   - req=1 in the first cycle only.
   - Next cycle: EPC=0x3010, Cause=0x0000_0400, SR reads 0x0000_0403.
   - req stays 0 for the remaining 5 cycles.
3. exccode_m=12, bd_m=1, pc_m=0x3024, EXL=0 -> req=1; next cycle EPC=0x3020, Cause=0x8000_0030; mtc0 in the same cycle is dropped.
4. Simultaneous enabled hwint and exccode_m=10 -> ExcCode=0 (interrupt wins), EPC=pc_m.
5. eret_m with EXL=1 and enabled hwint held high -> exl=0 after the edge, req=1 the cycle after; EPC updated to the new pc_m.
6. we=1, cp0_addr=14, wdata=0x3100 in the same cycle as eret_m -> epc_out=0x3100 that cycle.
7. SR=0x0000_0400 (IE=0) with hwint[0]=1 -> req=0 while Cause.IP[10] reads 1.

Source files
------------

// File: rtl/cp0_intr_ctrl.sv
// Coprocessor-0 register file and interrupt/exception arbiter beside the M stage.
// Holds SR/Cause/EPC/PRId and decides, combinationally, when to redirect to the handler.
module cp0_intr_ctrl #(
  parameter logic [31:0] PRID_VAL     = 32'h2021_0007,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  hwint,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exccode_m,
  input  logic        eret_m,
  input  logic        we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        req,
  output logic [31:0] handler_pc,
  output logic [31:0] epc_out,
  output logic        exl
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  // Interrupts look at the live lines so a request is taken in the cycle it appears.
  always_comb begin
    int_req = ie_q & ~exl_q & (|(hwint & im_q));
    exc_req = ~exl_q & (exccode_m != 5'd0);
    req     = ~reset & (int_req | exc_req);
  end

  always_comb begin
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    bd_d      = bd_q;
    ip_d      = hwint;
    exccode_d = exccode_q;
    epc_d     = epc_q;
    if (reset) begin
      im_d      = 6'd0;
      exl_d     = 1'b0;
      ie_d      = 1'b0;
      bd_d      = 1'b0;
      ip_d      = 6'd0;
      exccode_d = 5'd0;
      epc_d     = 32'd0;
    end else if (req) begin
      // The M-stage instruction is flushed, so its eret/mtc0 side effects are dropped.
      exl_d     = 1'b1;
      bd_d      = bd_m;
      epc_d     = bd_m ? (pc_m - 32'd4) : pc_m;
      exccode_d = int_req ? 5'd0 : exccode_m;
    end else begin
      if (eret_m) begin
        exl_d = 1'b0;
      end
      if (we) begin
        if (cp0_addr == ADDR_SR) begin
          im_d  = wdata[15:10];
          exl_d = wdata[1];
          ie_d  = wdata[0];
        end else if (cp0_addr == ADDR_EPC) begin
          epc_d = wdata;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    im_q      <= im_d;
    exl_q     <= exl_d;
    ie_q      <= ie_d;
    bd_q      <= bd_d;
    ip_q      <= ip_d;
    exccode_q <= exccode_d;
    epc_q     <= epc_d;
  end

  always_comb begin
    sr_val    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    cause_val = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'd0};
    case (cp0_addr)
      ADDR_SR:    rdata = sr_val;
      ADDR_CAUSE: rdata = cause_val;
      ADDR_EPC:   rdata = epc_q;
      ADDR_PRID:  rdata = PRID_VAL;
      default:    rdata = 32'd0;
    endcase
    // Forward an in-flight EPC write so an eret in the same cycle returns to it.
    epc_out    = (we && (cp0_addr == ADDR_EPC)) ? wdata : epc_q;
    handler_pc = HANDLER_ADDR;
    exl        = exl_q;
  end

endmodule
